mips_control_sequencer: RTL and testbench
=========================================

// Module: mips_control_sequencer
// PURPOSE
//  Multicycle control FSM that drives the single-datapath MIPS core's control inputs.
//  Per instruction it steps the instruction address (PC) and reads the instruction word from
//  the Instruction Register. It decodes the opcode, then sequences the datapath signals:
//  immediate, regdest, mem_r_w, mem_to_regfile, write_back.
//  It sits beside the datapath. It replaces the hand-driven control pins, so programs run unattended.
// PARAMETERS
//  ADDR_W    16   width of instruction address (PC); PC wraps modulo 2**ADDR_W
//  RESET_PC  0    PC value after reset and on each restart
// PORTS
//  clk             in   1       single clock; all state changes on rising edge
//  rst             in   1       asynchronous, active-high reset
//  start           in   1       run request; sampled only in IDLE or HALT
//  instr           in   32      instruction word from Instruction Register read port
//  zf              in   1       ALU zero flag from datapath
//  pc_addr         out  ADDR_W  instruction address to Instruction Register
//  ir_r_w          out  1       1=read IR (always 1 while sequencing; IR writes are external)
//  immediate       out  1       1=sign-extended imm as ALU operand B and I-type ALU ctrl
//  regdest         out  1       1=rd is destination, 0=rt
//  mem_r_w         out  1       1=read data memory, 0=write (asserted 0 for exactly 1 cycle per sw)
//  mem_to_regfile  out  1       1=write back memory data, 0=ALU result
//  write_back      out  1       register-file write enable (pulse, exactly 1 cycle per write)
//  busy            out  1       1 from FETCH entry until HALT/IDLE
//  done            out  1       1 while in HALT
//  illegal         out  1       1 while in HALT if halt was caused by an undefined opcode
// BEHAVIOUR
//  - Reset (async): state=IDLE, pc_addr=RESET_PC, ir_r_w=1, mem_r_w=1, all other outputs 0.
//    Reset mid-instruction kills write_back and any memory write at once; no partial commit.
//  - States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_M, EXEC_B, MEM_RD, MEM_WR, WB, HALT.
//  - IDLE: start=1 -> FETCH, busy=1. start ignored while busy.
//  - FETCH: pc_addr stable, IR read (synchronous). -> DECODE.
//  - DECODE: latch instr into internal ir_q; classify opcode = ir_q[31:26]:
//      0x00 R-type->EXEC_R; 0x23 lw, 0x2B sw->EXEC_M; 0x04 beq->EXEC_B; 0x3F halt->HALT;
//      0x08..0x0F I-ALU->EXEC_I; any other->HALT with illegal=1 (PC not advanced).
//  - EXEC_R: immediate=0, regdest=1 -> WB.   EXEC_I: immediate=1, regdest=0 -> WB.
//  - EXEC_M: immediate=1 (address = rs+imm). lw->MEM_RD; sw->MEM_WR.
//  - MEM_RD: mem_r_w=1, mem_to_regfile=1, regdest=0 -> WB (mem_to_regfile held through WB).
//  - MEM_WR: mem_r_w=0 one cycle; pc<=pc+1 -> FETCH.
//  - WB: write_back=1 one cycle; pc<=pc+1 -> FETCH. Control outputs of the EXEC state are held stable through WB.
//  - EXEC_B: immediate=0; zf sampled at clock edge: zf=1 -> pc<=pc+1+sext(ir_q[15:0]) truncated to
//    ADDR_W, else pc<=pc+1 -> FETCH. No write_back.
//  - Latency (start of FETCH to next FETCH): R/I-ALU 4, sw 4, lw 5, beq 3 cycles.
//  - HALT: busy=0, done=1, outputs at reset values except pc_addr (holds) and done/illegal.
//    start=1 -> pc<=RESET_PC, clear done/illegal, -> FETCH.
//  - PC wrap: pc=2**ADDR_W-1 increments to 0; a negative branch offset wraps likewise.
//  - write_back and mem_r_w=0 are never asserted in the same cycle.
// STRUCTURE
//  - Package mips_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_HALT, I-ALU range),
//    state enum/localparams, instruction field slice positions.
//  - Sub-module mips_opcode_decoder: combinational opcode -> class {R, I_ALU, LOAD, STORE, BRANCH, HALT, ILLEGAL}.
//  - Top: state register, PC register, ir_q register, registered-state output decode.
// TESTING
//  1 Reset: assert rst mid-WB -> write_back=0 immediately; pc_addr=0, busy=0, mem_r_w=1.
//  2 R-type add at PC 0, start pulse -> FETCH,DECODE,EXEC_R,WB; write_back=1 in 4th cycle only, regdest=1; pc_addr=1.
//  3 lw (0x23) at PC 5 -> 5 cycles; mem_to_regfile=1 in MEM_RD and WB; write_back 1 cycle; pc_addr=6.
//  4 sw (0x2B) -> mem_r_w=0 exactly 1 cycle, write_back never 1; pc_addr advances by 1.
//  5 beq offset -3 at PC 10: zf=1 -> pc_addr=8; zf=0 -> pc_addr=11. beq offset +1 at PC 0xFFFF -> pc_addr=1 (wrap).
//  6 opcode 0x3F -> done=1, illegal=0, busy=0; opcode 0x3E -> done=1, illegal=1; start -> pc_addr=RESET_PC, FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer.
// Contents: instruction field positions, opcode constants, the FSM state and
// opcode-class enums, the registered control bundle, and helpers that map a
// decoded class to its execute state and a state to its control outputs.
package mips_ctrl_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

    localparam logic [OPCODE_W-1:0] OP_RTYPE   = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_BEQ     = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_IALU_LO = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_IALU_HI = 6'h0F;
    localparam logic [OPCODE_W-1:0] OP_LW      = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW      = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_HALT    = 6'h3F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_M,
        S_EXEC_B,
        S_MEM_RD,
        S_MEM_WR,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    // Registered control bundle driven onto the datapath.
    typedef struct packed {
        logic ir_r_w;
        logic immediate;
        logic regdest;
        logic mem_r_w;
        logic mem_to_regfile;
        logic write_back;
        logic busy;
        logic done;
        logic illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        ir_r_w:         1'b1,
        immediate:      1'b0,
        regdest:        1'b0,
        mem_r_w:        1'b1,
        mem_to_regfile: 1'b0,
        write_back:     1'b0,
        busy:           1'b0,
        done:           1'b0,
        illegal:        1'b0
    };

    // State entered from DECODE for a given opcode class.
    function automatic state_e decode_target(input op_class_e cls);
        state_e st;
        st = S_HALT;
        case (cls)
            CLS_R:      st = S_EXEC_R;
            CLS_I_ALU:  st = S_EXEC_I;
            CLS_LOAD:   st = S_EXEC_M;
            CLS_STORE:  st = S_EXEC_M;
            CLS_BRANCH: st = S_EXEC_B;
            default:    st = S_HALT;
        endcase
        return st;
    endfunction

    // Control outputs presented while in state st; cls selects what WB holds
    // over from the preceding execute/memory state and why HALT was entered.
    function automatic ctrl_t ctrl_for(input state_e st, input op_class_e cls);
        ctrl_t c;
        c      = CTRL_RESET;
        c.busy = 1'b1;
        case (st)
            S_IDLE: c.busy = 1'b0;
            S_HALT: begin
                c.busy    = 1'b0;
                c.done    = 1'b1;
                c.illegal = (cls == CLS_ILLEGAL);
            end
            S_EXEC_R: c.regdest   = 1'b1;
            S_EXEC_I: c.immediate = 1'b1;
            S_EXEC_M: c.immediate = 1'b1;
            S_MEM_RD: begin
                c.immediate      = 1'b1;
                c.mem_to_regfile = 1'b1;
            end
            S_MEM_WR: begin
                c.immediate = 1'b1;
                c.mem_r_w   = 1'b0;
            end
            S_WB: begin
                c.write_back = 1'b1;
                case (cls)
                    CLS_R:     c.regdest   = 1'b1;
                    CLS_I_ALU: c.immediate = 1'b1;
                    CLS_LOAD: begin
                        c.immediate      = 1'b1;
                        c.mem_to_regfile = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_opcode_decoder.sv
// Combinational opcode classifier.
// Ports: opcode (in, instruction bits 31:26), op_class_c (out, decoded class).
module mips_opcode_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_e           op_class_c
);

    // Anything not explicitly recognised is illegal.
    always_comb begin
        op_class_c = CLS_ILLEGAL;
        if (opcode == OP_RTYPE) begin
            op_class_c = CLS_R;
        end else if (opcode == OP_LW) begin
            op_class_c = CLS_LOAD;
        end else if (opcode == OP_SW) begin
            op_class_c = CLS_STORE;
        end else if (opcode == OP_BEQ) begin
            op_class_c = CLS_BRANCH;
        end else if (opcode == OP_HALT) begin
            op_class_c = CLS_HALT;
        end else if ((opcode >= OP_IALU_LO) && (opcode <= OP_IALU_HI)) begin
            op_class_c = CLS_I_ALU;
        end
    end

endmodule

// File: rtl/mips_control_sequencer.sv
// Multicycle control FSM for the single-datapath MIPS core. Steps the PC,
// latches the fetched instruction, decodes it and sequences the datapath
// controls until a halt or undefined opcode is reached.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           run request (honoured in IDLE or HALT only)
//   instr, zf       instruction word from the IR, ALU zero flag
//   pc_addr         instruction address
//   ir_r_w          IR read enable (held 1)
//   immediate, regdest, mem_r_w, mem_to_regfile, write_back  datapath controls
//   busy, done, illegal                                      run status
module mips_control_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zf,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic               ir_r_w,
    output logic               immediate,
    output logic               regdest,
    output logic               mem_r_w,
    output logic               mem_to_regfile,
    output logic               write_back,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    state_e             state;
    op_class_e          cls_q;
    op_class_e          dec_cls;
    ctrl_t              ctrl;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir_q;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  br_target;
    logic               unused_ir_bits;

    mips_opcode_decoder u_decoder (
        .opcode     (instr[OPCODE_MSB:OPCODE_LSB]),
        .op_class_c (dec_cls)
    );

    // Next sequential PC and beq target; both wrap modulo 2**ADDR_W.
    assign pc_inc    = pc + ADDR_W'(1);
    assign br_target = pc_inc + ADDR_W'($signed(ir_q[IMM_MSB:IMM_LSB]));

    // Only the immediate field of ir_q is consumed; the class is kept in cls_q.
    assign unused_ir_bits = ^ir_q[OPCODE_MSB:IMM_MSB+1];

    // Sequencer: state, PC, instruction latch and registered controls together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir_q  <= '0;
            cls_q <= CLS_R;
            ctrl  <= CTRL_RESET;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        ctrl  <= ctrl_for(S_FETCH, cls_q);
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                    ctrl  <= ctrl_for(S_DECODE, cls_q);
                end
                S_DECODE: begin
                    ir_q  <= instr;
                    cls_q <= dec_cls;
                    state <= decode_target(dec_cls);
                    ctrl  <= ctrl_for(decode_target(dec_cls), dec_cls);
                end
                S_EXEC_R, S_EXEC_I, S_MEM_RD: begin
                    state <= S_WB;
                    ctrl  <= ctrl_for(S_WB, cls_q);
                end
                S_EXEC_M: begin
                    if (cls_q == CLS_LOAD) begin
                        state <= S_MEM_RD;
                        ctrl  <= ctrl_for(S_MEM_RD, cls_q);
                    end else begin
                        state <= S_MEM_WR;
                        ctrl  <= ctrl_for(S_MEM_WR, cls_q);
                    end
                end
                S_MEM_WR, S_WB: begin
                    pc    <= pc_inc;
                    state <= S_FETCH;
                    ctrl  <= ctrl_for(S_FETCH, cls_q);
                end
                S_EXEC_B: begin
                    pc    <= zf ? br_target : pc_inc;
                    state <= S_FETCH;
                    ctrl  <= ctrl_for(S_FETCH, cls_q);
                end
                S_HALT: begin
                    // Restart from RESET_PC; done/illegal clear on leaving HALT.
                    if (start) begin
                        pc    <= RESET_PC;
                        state <= S_FETCH;
                        ctrl  <= ctrl_for(S_FETCH, cls_q);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ctrl  <= CTRL_RESET;
                end
            endcase
        end
    end

    assign pc_addr        = pc;
    assign ir_r_w         = ctrl.ir_r_w;
    assign immediate      = ctrl.immediate;
    assign regdest        = ctrl.regdest;
    assign mem_r_w        = ctrl.mem_r_w;
    assign mem_to_regfile = ctrl.mem_to_regfile;
    assign write_back     = ctrl.write_back;
    assign busy           = ctrl.busy;
    assign done           = ctrl.done;
    assign illegal        = ctrl.illegal;

endmodule

// File: tb/tb_mips_control_sequencer.sv
// Scoreboard bench for mips_control_sequencer: stimulus loads small programs
// into an instruction memory model, starts the sequencer and queues the
// hand-derived per-cycle output vectors; a monitor pops and compares one
// vector per falling edge.
module tb_mips_control_sequencer;

    // {ir_r_w, immediate, regdest, mem_r_w, mem_to_regfile, write_back, busy, done, illegal}
    localparam logic [8:0] V_IDLE = 9'b1_0010_0000;
    localparam logic [8:0] V_FD   = 9'b1_0010_0100; // FETCH, DECODE, EXEC_B
    localparam logic [8:0] V_R    = 9'b1_0110_0100;
    localparam logic [8:0] V_RWB  = 9'b1_0110_1100;
    localparam logic [8:0] V_I    = 9'b1_1010_0100; // EXEC_I, EXEC_M
    localparam logic [8:0] V_IWB  = 9'b1_1010_1100;
    localparam logic [8:0] V_MRD  = 9'b1_1011_0100;
    localparam logic [8:0] V_LWB  = 9'b1_1011_1100;
    localparam logic [8:0] V_MWR  = 9'b1_1000_0100;
    localparam logic [8:0] V_HALT = 9'b1_0010_0010;
    localparam logic [8:0] V_ILL  = 9'b1_0010_0011;

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_ADDI = 32'h2022_0001;
    localparam logic [31:0] I_BEQ  = 32'h1000_0000;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;
    localparam logic [31:0] I_ILL  = 32'hF800_0000;

    typedef struct {
        int          id;
        logic [15:0] pc;
        logic [8:0]  v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic        zf;
    logic [15:0] pc_addr;
    logic        ir_r_w, immediate, regdest, mem_r_w, mem_to_regfile;
    logic        write_back, busy, done, illegal;

    logic [31:0] imem [0:65535];
    logic        zmap [0:65535];

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;

    mips_control_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .instr          (instr),
        .zf             (zf),
        .pc_addr        (pc_addr),
        .ir_r_w         (ir_r_w),
        .immediate      (immediate),
        .regdest        (regdest),
        .mem_r_w        (mem_r_w),
        .mem_to_regfile (mem_to_regfile),
        .write_back     (write_back),
        .busy           (busy),
        .done           (done),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    assign instr = imem[pc_addr];
    assign zf    = zmap[pc_addr];

    // Monitor: one expected vector per falling edge while the scoreboard holds entries.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [8:0] got;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {ir_r_w, immediate, regdest, mem_r_w, mem_to_regfile,
                   write_back, busy, done, illegal};
            n_cmp++;
            if (pc_addr !== e.pc || got !== e.v) begin
                n_bad++;
                $display("FAIL step%0d: pc_addr=%h ctrl=%b, required pc_addr=%h ctrl=%b",
                         e.id, pc_addr, got, e.pc, e.v);
            end
        end
    end

    task automatic ex(input logic [15:0] pc, input logic [8:0] v);
        exp_t e;
        e.id = n_push;
        e.pc = pc;
        e.v  = v;
        n_push++;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic drain(input int max_cyc);
        int c;
        c = 0;
        while (sb_q.size() > 0 && c < max_cyc) begin
            @(posedge clk);
            c++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries pending after %0d cycles, required 0",
                     sb_q.size(), max_cyc);
            sb_q.delete();
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 65536; a++) begin
            imem[a] = I_HALT;
            zmap[a] = 1'b0;
        end
    endtask

    // Call at posedge: pulse start for one edge (expectations queued in between).
    task automatic start_on();
        #1 start = 1'b1;
    endtask

    task automatic start_off();
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_mem();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc",   32'(pc_addr), 32'h0);
        chk("rst_ctrl", 32'({ir_r_w, immediate, regdest, mem_r_w, mem_to_regfile,
                             write_back, busy, done, illegal}), 32'(V_IDLE));
        rst = 1'b0;
        @(posedge clk);

        // Run 1: add, beq +3 taken, lw, sw, addi, halt
        imem[0] = I_ADD;
        imem[1] = I_BEQ | 32'h0000_0003; zmap[1] = 1'b1;
        imem[5] = I_LW;
        imem[6] = I_SW;
        imem[7] = I_ADDI;
        imem[8] = I_HALT;
        start_on();
        ex(16'd0, V_IDLE);
        ex(16'd0, V_FD);  ex(16'd0, V_FD);  ex(16'd0, V_R);   ex(16'd0, V_RWB);
        ex(16'd1, V_FD);  ex(16'd1, V_FD);  ex(16'd1, V_FD);
        ex(16'd5, V_FD);  ex(16'd5, V_FD);  ex(16'd5, V_I);   ex(16'd5, V_MRD); ex(16'd5, V_LWB);
        ex(16'd6, V_FD);  ex(16'd6, V_FD);  ex(16'd6, V_I);   ex(16'd6, V_MWR);
        ex(16'd7, V_FD);  ex(16'd7, V_FD);  ex(16'd7, V_I);   ex(16'd7, V_IWB);
        ex(16'd8, V_FD);  ex(16'd8, V_FD);  ex(16'd8, V_HALT); ex(16'd8, V_HALT);
        start_off();
        drain(60);

        // Run 2: restart, beq -3 taken at 10 -> 8, undefined opcode at 8
        clear_mem();
        imem[0]  = I_BEQ | 32'h0000_0009; zmap[0]  = 1'b1;
        imem[10] = I_BEQ | 32'h0000_FFFD; zmap[10] = 1'b1;
        imem[8]  = I_ILL;
        start_on();
        ex(16'd8,  V_HALT);
        ex(16'd0,  V_FD); ex(16'd0,  V_FD); ex(16'd0,  V_FD);
        ex(16'd10, V_FD); ex(16'd10, V_FD); ex(16'd10, V_FD);
        ex(16'd8,  V_FD); ex(16'd8,  V_FD); ex(16'd8,  V_ILL); ex(16'd8, V_ILL);
        start_off();
        drain(40);

        // Run 3: beq -3 not taken at 10 -> 11, jump to 0xFFFF, +1 wraps to 1, halt
        clear_mem();
        imem[0]      = I_BEQ | 32'h0000_0009; zmap[0]      = 1'b1;
        imem[10]     = I_BEQ | 32'h0000_FFFD; zmap[10]     = 1'b0;
        imem[11]     = I_BEQ | 32'h0000_FFF3; zmap[11]     = 1'b1;
        imem[16'hFFFF] = I_BEQ | 32'h0000_0001; zmap[16'hFFFF] = 1'b1;
        imem[1]      = I_HALT;
        start_on();
        ex(16'd8,  V_ILL);
        ex(16'd0,  V_FD); ex(16'd0,  V_FD); ex(16'd0,  V_FD);
        ex(16'd10, V_FD); ex(16'd10, V_FD); ex(16'd10, V_FD);
        ex(16'd11, V_FD); ex(16'd11, V_FD); ex(16'd11, V_FD);
        ex(16'hFFFF, V_FD); ex(16'hFFFF, V_FD); ex(16'hFFFF, V_FD);
        ex(16'd1,  V_FD); ex(16'd1,  V_FD); ex(16'd1, V_HALT); ex(16'd1, V_HALT);
        start_off();
        drain(50);

        // Run 4: reset asserted during the WB cycle of an add
        clear_mem();
        imem[0] = I_ADD;
        start_on();
        ex(16'd1, V_HALT);
        ex(16'd0, V_FD); ex(16'd0, V_FD); ex(16'd0, V_R);
        start_off();
        drain(20);
        #2;
        chk("wb_before_rst", 32'(write_back), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_wb",      32'(write_back), 32'h0);
        chk("rst_regdest", 32'(regdest),    32'h0);
        chk("rst_pc_wb",   32'(pc_addr),    32'h0);
        chk("rst_busy",    32'(busy),       32'h0);
        chk("rst_mem_r_w", 32'(mem_r_w),    32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ex(16'd0, V_IDLE);
        ex(16'd0, V_IDLE);
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
